btn_event_ctrl: RTL and testbench

//  Front-end scheduler for the panel buttons of the pulse-counter design. Shares one tick

---
 rtl/btn_event_ctrl_pkg.sv | 25 ++
 rtl/btn_db_core.sv | 109 ++++++++++
 rtl/btn_event_ctrl.sv | 138 +++++++++++++
 tb/tb_btn_event_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_event_ctrl_pkg.sv
// Shared definitions for the button event front-end: debounce state
// encodings and the width helpers used to size the event index and
// the auto-repeat hold counter.
package btn_event_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_ZERO = 2'b00,
        ST_W1   = 2'b01,
        ST_ONE  = 2'b10,
        ST_W0   = 2'b11
    } db_state_t;

    // Width of the event index; a single button still gets a 1-bit id.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width needed to hold the larger of the two repeat reload values.
    function automatic int hold_width(input int dly, input int rate);
        int m;
        m = (dly > rate) ? dly : rate;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/btn_db_core.sv
// One button lane: 2-FF synchroniser, tick-based debounce FSM and the
// hold counter that turns a long press into auto-repeat requests.
module btn_db_core
    import btn_event_ctrl_pkg::*;
#(
    parameter int STABLE_TICKS = 3,
    parameter int RPT_DLY      = 50,
    parameter int RPT_RATE     = 10,
    parameter int RPT_EN       = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic tick,
    output logic db,
    output logic press_set,
    output logic rpt_set
);

    localparam int              HOLD_W      = hold_width(RPT_DLY, RPT_RATE);
    localparam logic [2:0]      STABLE_LAST = 3'(STABLE_TICKS - 1);
    localparam logic [HOLD_W-1:0] DLY_LD    = HOLD_W'(RPT_DLY);
    localparam logic [HOLD_W-1:0] RATE_LD   = HOLD_W'(RPT_RATE);

    logic [1:0]        sync_q;
    logic              level;
    db_state_t         state;
    logic [2:0]        cnt;
    logic [HOLD_W-1:0] hold;
    logic              rise_now;

    assign level    = sync_q[1];
    assign db       = (state == ST_ONE) || (state == ST_W0);
    // The W1 -> ONE step: stable high long enough and this tick completes it.
    assign rise_now = (state == ST_W1) && level && tick && (cnt == STABLE_LAST);

    // Bring the raw asynchronous button level into the clk domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], btn};
    end

    // Debounce FSM; a level change beats a coincident tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_ZERO;
            cnt       <= 3'd0;
            press_set <= 1'b0;
        end else begin
            press_set <= 1'b0;
            case (state)
                ST_ZERO: begin
                    if (level) begin
                        state <= ST_W1;
                        cnt   <= 3'd0;
                    end
                end
                ST_W1: begin
                    if (!level) begin
                        state <= ST_ZERO;
                    end else if (tick) begin
                        if (cnt == STABLE_LAST) begin
                            state     <= ST_ONE;
                            press_set <= 1'b1;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                ST_ONE: begin
                    if (!level) begin
                        state <= ST_W0;
                        cnt   <= 3'd0;
                    end
                end
                ST_W0: begin
                    if (level) begin
                        state <= ST_ONE;
                    end else if (tick) begin
                        if (cnt == STABLE_LAST) state <= ST_ZERO;
                        else                    cnt   <= cnt + 3'd1;
                    end
                end
                default: state <= ST_ZERO;
            endcase
        end
    end

    // Hold counter: armed on a debounced press, counts ticks while db is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold    <= '0;
            rpt_set <= 1'b0;
        end else begin
            rpt_set <= 1'b0;
            if (rise_now) begin
                hold <= DLY_LD;
            end else if ((RPT_EN != 0) && db && tick && (hold != '0)) begin
                if (hold == HOLD_W'(1)) begin
                    rpt_set <= 1'b1;
                    hold    <= RATE_LD;
                end else begin
                    hold <= hold - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/btn_event_ctrl.sv
// Button front-end top: shared tick prescaler, one debounce lane per
// button, per-button pending flags and a round-robin arbiter that
// presents one registered valid/ready event stream.
module btn_event_ctrl
    import btn_event_ctrl_pkg::*;
#(
    parameter int  NBTN         = 3,
    parameter int  TICK_W       = 13,
    parameter int  STABLE_TICKS = 3,
    parameter int  RPT_DLY      = 50,
    parameter int  RPT_RATE     = 10,
    parameter int  RPT_EN       = 1,
    localparam int ID_W         = id_width(NBTN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NBTN-1:0] btn,
    output logic [NBTN-1:0] db,
    output logic            m_tick,
    output logic            evt_valid,
    output logic [ID_W-1:0] evt_id,
    output logic            evt_rpt,
    input  logic            evt_ready
);

    logic [TICK_W-1:0] pre_cnt;
    logic [NBTN-1:0]   press_set;
    logic [NBTN-1:0]   rpt_set;
    logic [NBTN-1:0]   p;
    logic [NBTN-1:0]   r;
    logic [NBTN-1:0]   acc_mask;
    logic [NBTN-1:0]   cand;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   start;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   pos_id;
    logic              win_found;
    logic              accept;
    int                pos;

    assign accept = evt_valid & evt_ready;

    // Index after v, wrapping at NBTN.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
        if (v == ID_W'(NBTN - 1)) return '0;
        else                      return v + 1'b1;
    endfunction

    // Free-running prescaler; m_tick is registered so the first one lands
    // a full 2**TICK_W clocks after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt <= '0;
            m_tick  <= 1'b0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
            m_tick  <= (pre_cnt == '1);
        end
    end

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        btn_db_core #(
            .STABLE_TICKS (STABLE_TICKS),
            .RPT_DLY      (RPT_DLY),
            .RPT_RATE     (RPT_RATE),
            .RPT_EN       (RPT_EN)
        ) u_core (
            .clk       (clk),
            .reset     (reset),
            .btn       (btn[i]),
            .tick      (m_tick),
            .db        (db[i]),
            .press_set (press_set[i]),
            .rpt_set   (rpt_set[i])
        );
    end

    // One-hot of the button whose event is being transferred this cycle.
    always_comb begin
        acc_mask = '0;
        if (accept) acc_mask[evt_id] = 1'b1;
    end

    // Pending bits: a new set merges into an existing one and beats a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p <= '0;
            r <= '0;
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                if (press_set[i] || rpt_set[i]) begin
                    p[i] <= 1'b1;
                    r[i] <= rpt_set[i];
                end else if (acc_mask[i]) begin
                    p[i] <= 1'b0;
                end
            end
        end
    end

    // Round-robin search from the pointer; on accept the search already
    // starts after the accepted id so the next winner can follow at once.
    always_comb begin
        cand      = p & ~acc_mask;
        start     = accept ? wrap_inc(evt_id) : rr_ptr;
        win_found = 1'b0;
        win_id    = '0;
        pos       = 0;
        pos_id    = '0;
        for (int k = 0; k < NBTN; k++) begin
            pos    = (int'(start) + k) % NBTN;
            pos_id = ID_W'(pos);
            if (!win_found && cand[pos_id]) begin
                win_found = 1'b1;
                win_id    = pos_id;
            end
        end
    end

    // Output registers: reload only when idle or on a transfer, so a
    // stalled offer holds its id and flavour.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_rpt   <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            if (accept) rr_ptr <= wrap_inc(evt_id);
            if (!evt_valid || accept) begin
                evt_valid <= win_found;
                evt_id    <= win_id;
                evt_rpt   <= win_found & r[win_id];
            end
        end
    end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with a short prescaler (tick every 16 clk).
`timescale 1ns/1ps
module tb_btn_event_ctrl;

    localparam int NBTN = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] btn = 3'b000;
    logic       evt_ready = 1'b1;
    logic [2:0] db;
    logic       m_tick;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_rpt;

    always #5 clk = ~clk;

    btn_event_ctrl #(
        .NBTN(3), .TICK_W(4), .STABLE_TICKS(3),
        .RPT_DLY(4), .RPT_RATE(2), .RPT_EN(1)
    ) dut (
        .clk(clk), .reset(reset), .btn(btn), .db(db), .m_tick(m_tick),
        .evt_valid(evt_valid), .evt_id(evt_id), .evt_rpt(evt_rpt),
        .evt_ready(evt_ready)
    );

    int tests = 0;
    int fails = 0;
    int tick_cnt = 0;
    int ev_id[$];
    int ev_rpt[$];
    int ev_tick[$];

    // Tick counter and transfer log, sampled on the falling edge.
    always @(negedge clk) begin
        if (m_tick) tick_cnt++;
        if (evt_valid && evt_ready) begin
            ev_id.push_back(int'(evt_id));
            ev_rpt.push_back(int'(evt_rpt));
            ev_tick.push_back(tick_cnt);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting, expected event did not occur", name);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        ev_id.delete();
        ev_rpt.delete();
        ev_tick.delete();
    endtask

    // Return just after the clock edge that consumed a tick.
    task automatic align_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (m_tick) seen = 1'b1;
        end
        if (!seen) fail_now("align_tick");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_db_bit(input int idx, input logic val, input int budget,
                               input string name, output int at_tick);
        bit seen = 1'b0;
        at_tick = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (db[idx] === val) begin
                seen = 1'b1;
                at_tick = tick_cnt;
            end
        end
        if (!seen) fail_now(name);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_db_zero(input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (db === 3'b000) seen = 1'b1;
        end
        if (!seen) fail_now(name);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_events(input int n, input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (ev_id.size() >= n) seen = 1'b1;
        end
        if (!seen) fail_now(name);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (evt_valid === 1'b1) seen = 1'b1;
        end
        if (!seen) fail_now(name);
    endtask

    typedef struct {
        logic [2:0] mask;
        int         nevt;
        int         id0;
        int         id1;
        int         id2;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int t0, trise, tfall, cap_id, cap_rpt, got, exp_id, nedge, npress;
        bit stable, dropped, found, quiet;
        int rpt_off[5];
        int rpt_flag[5];

        // Round-robin expectations; the pointer carries over between rows.
        vecs[0] = '{3'b111, 3, 0, 1, 2};
        vecs[1] = '{3'b110, 2, 1, 2, 0};
        vecs[2] = '{3'b101, 2, 0, 2, 0};
        vecs[3] = '{3'b010, 1, 1, 0, 0};
        vecs[4] = '{3'b101, 2, 2, 0, 0};
        vecs[5] = '{3'b011, 2, 1, 0, 0};
        vecs[6] = '{3'b100, 1, 2, 0, 0};
        rpt_off  = '{0, 4, 6, 8, 10};
        rpt_flag = '{0, 1, 1, 1, 1};

        // Reset state
        #1 reset = 1'b0;
        step(3);
        check("rst_db", int'(db), 0);
        check("rst_m_tick", int'(m_tick), 0);
        check("rst_valid", int'(evt_valid), 0);
        check("rst_id", int'(evt_id), 0);
        check("rst_rpt", int'(evt_rpt), 0);
        reset = 1'b1;
        step(2);

        // Simultaneous and mixed presses through the arbiter
        for (int v = 0; v < 7; v++) begin
            clear_events();
            align_tick();
            btn = vecs[v].mask;
            wait_events(vecs[v].nevt, 100, $sformatf("vec%0d_wait", v));
            btn = 3'b000;
            wait_db_zero(100, $sformatf("vec%0d_release", v));
            step(5);
            check($sformatf("vec%0d_count", v), ev_id.size(), vecs[v].nevt);
            for (int k = 0; k < vecs[v].nevt; k++) begin
                exp_id = (k == 0) ? vecs[v].id0 : (k == 1) ? vecs[v].id1 : vecs[v].id2;
                got = (k < ev_id.size()) ? ev_id[k] : -1;
                check($sformatf("vec%0d_id%0d", v, k), got, exp_id);
                got = (k < ev_rpt.size()) ? ev_rpt[k] : -1;
                check($sformatf("vec%0d_rpt%0d", v, k), got, 0);
            end
        end

        // Glitchy press on button 0
        clear_events();
        for (int g = 0; g < 5; g++) begin
            btn[0] = 1'b1;
            step(6);
            btn[0] = 1'b0;
            step(4);
        end
        check("glitch_db_low", int'(db[0]), 0);
        check("glitch_no_event", ev_id.size(), 0);
        align_tick();
        t0 = tick_cnt;
        btn[0] = 1'b1;
        wait_db_bit(0, 1'b1, 100, "glitch_rise", trise);
        check("glitch_rise_ticks", trise - t0, 3);
        wait_events(1, 20, "glitch_event");
        btn[0] = 1'b0;
        wait_db_bit(0, 1'b0, 100, "glitch_fall", tfall);
        step(5);
        check("glitch_evt_count", ev_id.size(), 1);
        check("glitch_evt_id", (ev_id.size() > 0) ? ev_id[0] : -1, 0);
        check("glitch_evt_rpt", (ev_rpt.size() > 0) ? ev_rpt[0] : -1, 0);

        // Long hold: press, then repeats at 4, 6, 8 ticks (10 falls inside W0)
        clear_events();
        align_tick();
        t0 = tick_cnt;
        btn[0] = 1'b1;
        wait_db_bit(0, 1'b1, 100, "hold_rise", trise);
        check("hold_rise_ticks", trise - t0, 3);
        wait_events(4, 250, "hold_repeats");
        btn[0] = 1'b0;
        wait_db_bit(0, 1'b0, 100, "hold_fall", tfall);
        step(5);
        check("hold_evt_count", ev_id.size(), 5);
        for (int k = 0; k < 5; k++) begin
            got = (k < ev_tick.size()) ? ev_tick[k] - trise : -1;
            check($sformatf("hold_evt%0d_tick", k), got, rpt_off[k]);
            got = (k < ev_rpt.size()) ? ev_rpt[k] : -1;
            check($sformatf("hold_evt%0d_rpt", k), got, rpt_flag[k]);
            got = (k < ev_id.size()) ? ev_id[k] : -1;
            check($sformatf("hold_evt%0d_id", k), got, 0);
        end

        // Back-pressure: offer stays stable, repeats merge into it
        evt_ready = 1'b0;
        clear_events();
        align_tick();
        btn[1] = 1'b1;
        wait_valid(100, "stall_valid");
        cap_id = int'(evt_id);
        cap_rpt = int'(evt_rpt);
        check("stall_id", cap_id, 1);
        check("stall_rpt", cap_rpt, 0);
        stable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (evt_valid !== 1'b1 || int'(evt_id) != cap_id || int'(evt_rpt) != cap_rpt)
                stable = 1'b0;
        end
        check("stall_stable_40", int'(stable), 1);
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            if (evt_valid !== 1'b1 || int'(evt_id) != cap_id || int'(evt_rpt) != cap_rpt)
                stable = 1'b0;
        end
        check("stall_stable_repeats", int'(stable), 1);
        @(posedge clk);
        #1;
        btn[1] = 1'b0;
        wait_db_bit(1, 1'b0, 100, "stall_fall", tfall);
        evt_ready = 1'b1;
        step(10);
        check("stall_evt_count", ev_id.size(), 1);
        check("stall_evt_id", (ev_id.size() > 0) ? ev_id[0] : -1, 1);
        check("stall_evt_rpt", (ev_rpt.size() > 0) ? ev_rpt[0] : -1, 0);
        check("stall_idle", int'(evt_valid), 0);

        // Short release inside W0 and re-press on button 2
        clear_events();
        align_tick();
        btn[2] = 1'b1;
        wait_db_bit(2, 1'b1, 100, "w0_rise", trise);
        wait_events(1, 20, "w0_press");
        btn[2] = 1'b0;
        dropped = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (db[2] !== 1'b1) dropped = 1'b1;
        end
        @(posedge clk);
        #1;
        btn[2] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (db[2] !== 1'b1) dropped = 1'b1;
        end
        check("w0_db_held", int'(dropped), 0);
        @(posedge clk);
        #1;
        btn[2] = 1'b0;
        wait_db_bit(2, 1'b0, 150, "w0_fall", tfall);
        step(5);
        npress = 0;
        foreach (ev_rpt[k]) if (ev_rpt[k] == 0) npress++;
        check("w0_press_count", npress, 1);
        check("w0_first_id", (ev_id.size() > 0) ? ev_id[0] : -1, 2);

        // Asynchronous reset while an event is offered
        evt_ready = 1'b0;
        clear_events();
        align_tick();
        btn[0] = 1'b1;
        wait_valid(100, "arst_valid");
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", int'(evt_valid), 0);
        check("arst_id", int'(evt_id), 0);
        check("arst_rpt", int'(evt_rpt), 0);
        check("arst_db", int'(db), 0);
        check("arst_m_tick", int'(m_tick), 0);
        btn = 3'b000;
        @(negedge clk);
        reset = 1'b1;
        nedge = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            nedge++;
            @(negedge clk);
            if (m_tick) found = 1'b1;
        end
        if (!found) fail_now("arst_first_tick");
        check("arst_first_tick_clks", nedge, 16);
        evt_ready = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (evt_valid !== 1'b0) quiet = 1'b0;
        end
        check("arst_event_lost", int'(quiet), 1);
        check("arst_no_transfer", ev_id.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
